// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU unit: FSM state codes,
// handshake level constants and the decoder opcodes that select a divide.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_ON     = 2'd2,
    DIV_END    = 2'd3
  } div_state_e;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // Execute-stage ALU opcodes the decoder maps onto start / signed_div.
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute-stage control (master)
// and the divider (slave).
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 signed_div;
  logic [WIDTH-1:0]     opa;
  logic [WIDTH-1:0]     opb;
  logic                 annul;
  logic                 busy;
  logic                 ready;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start, signed_div, opa, opb, annul,
    input  busy, ready, result
  );

  modport slave (
    input  start, signed_div, opa, opb, annul,
    output busy, ready, result
  );
endinterface

// File: rtl/div_unit_sub_step.sv
// One restoring-division iteration: shift the working register left and
// keep the trial subtraction of the divisor from its upper half if it fits.
module div_sub_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  work_i,
  input  logic [WIDTH-1:0]  divisor_i,
  output logic [2*WIDTH:0]  work_o
);

  logic [2*WIDTH:0] shifted_s;
  logic [WIDTH+1:0] diff_s;

  // Extra top bit on the difference acts as the borrow / sign flag.
  always_comb begin
    shifted_s = work_i << 1;
    diff_s    = {1'b0, shifted_s[2*WIDTH:WIDTH]} - {2'b00, divisor_i};
    work_o    = shifted_s;
    if (diff_s[WIDTH+1] == 1'b0) begin
      work_o = {diff_s[WIDTH:0], shifted_s[WIDTH-1:1], 1'b1};
    end else begin
      work_o = shifted_s;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU: magnitude restoring division over WIDTH iterations
// with sign fixup; result packs {remainder, quotient} like the ALU HILO.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e           state_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH:0]     work_q;
  logic [2*WIDTH:0]     work_step_s;
  logic [WIDTH-1:0]     divisor_q;
  logic                 signed_q;
  logic                 sign_a_q;
  logic                 sign_b_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 busy_q;
  logic                 ready_q;
  logic [WIDTH-1:0]     abs_a_s;
  logic [WIDTH-1:0]     abs_b_s;
  logic [WIDTH-1:0]     quot_s;
  logic [WIDTH-1:0]     rem_s;

  function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  div_sub_step #(.WIDTH(WIDTH)) u_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (work_step_s)
  );

  // Operand magnitudes at acceptance and signed result at completion.
  always_comb begin
    abs_a_s = negate_if(bus.opa, bus.signed_div & bus.opa[WIDTH-1]);
    abs_b_s = negate_if(bus.opb, bus.signed_div & bus.opb[WIDTH-1]);
    quot_s  = negate_if(work_q[WIDTH-1:0], signed_q & (sign_a_q ^ sign_b_q));
    rem_s   = negate_if(work_q[2*WIDTH-1:WIDTH], signed_q & sign_a_q);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      ready_q   <= DIV_RESULT_NOT_READY;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (bus.start == DIV_START && !bus.annul) begin
            busy_q <= 1'b1;
            if (bus.opb == '0) begin
              state_q <= DIV_BYZERO;
            end else begin
              state_q   <= DIV_ON;
              signed_q  <= bus.signed_div;
              sign_a_q  <= bus.opa[WIDTH-1];
              sign_b_q  <= bus.opb[WIDTH-1];
              work_q    <= {{(WIDTH+1){1'b0}}, abs_a_s};
              divisor_q <= abs_b_s;
              cnt_q     <= '0;
            end
          end else begin
            state_q <= DIV_IDLE;
          end
        end
        DIV_BYZERO: begin
          busy_q <= 1'b0;
          if (bus.annul) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
          end else begin
            state_q  <= DIV_END;
            result_q <= '0;
            ready_q  <= DIV_RESULT_READY;
          end
        end
        DIV_ON: begin
          if (bus.annul) begin
            state_q <= DIV_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(WIDTH)) begin
            state_q  <= DIV_END;
            result_q <= {rem_s, quot_s};
            busy_q   <= 1'b0;
            ready_q  <= DIV_RESULT_READY;
          end else begin
            work_q <= work_step_s;
            cnt_q  <= cnt_q + CW'(1);
          end
        end
        DIV_END: begin
          // A back-to-back request must first drop start for a cycle.
          if (bus.annul || bus.start == DIV_STOP) begin
            state_q <= DIV_IDLE;
            ready_q <= DIV_RESULT_NOT_READY;
          end else begin
            state_q <= DIV_END;
          end
        end
        default: begin
          state_q <= DIV_IDLE;
          busy_q  <= 1'b0;
          ready_q <= DIV_RESULT_NOT_READY;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.ready  = ready_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed, table-driven bench for div_unit plus hand-written sequences for
// divide-by-zero hold, annul and reset during an operation.
module tb_div_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [63:0] last_res;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.signed_div = sgn;
    bus.opa        = a;
    bus.opb        = b;
    bus.start      = 1'b1;
    @(posedge clk);
  endtask

  // Called right after the acceptance edge; returns at a negedge with ready seen.
  task automatic finish_op(input string name, input logic [63:0] exp, input int exp_lat, input logic drop);
    int   n;
    logic busy_ok;
    n = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    bus.opa        = 32'hDEAD_BEEF;
    bus.opb        = 32'h0000_0003;
    bus.signed_div = ~bus.signed_div;
    if (bus.busy !== 1'b1 || bus.ready !== 1'b0) busy_ok = 1'b0;
    while (n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.ready === 1'b1) break;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    check({name, " latency"}, 64'(n), 64'(exp_lat));
    check({name, " busy while working"}, {63'd0, busy_ok}, 64'd1);
    check({name, " result"}, bus.result, exp);
    check({name, " busy at ready"}, {63'd0, bus.busy}, 64'd0);
    last_res = exp;
    if (drop) begin
      bus.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check({name, " ready drop"}, {63'd0, bus.ready}, 64'd0);
      check({name, " result held"}, bus.result, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    last_res = 64'd0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.opa        = 32'd0;
    bus.opb        = 32'd0;
    bus.annul      = 1'b0;

    vecs[0] = '{"divu 100/7",        1'b0, 32'h0000_0064, 32'h0000_0007, 64'h00000002_0000000E, 33};
    vecs[1] = '{"div -7/2",          1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFFFFFF_FFFFFFFD, 33};
    vecs[2] = '{"divu fff9/2",       1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 64'h00000001_7FFFFFFC, 33};
    vecs[3] = '{"div min/-1",        1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 33};
    vecs[4] = '{"divu max/16",       1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 64'h0000000F_0FFFFFFF, 33};
    vecs[5] = '{"div 5/-9",          1'b1, 32'h0000_0005, 32'hFFFF_FFF7, 64'h00000005_00000000, 33};
    vecs[6] = '{"div 0/3",           1'b1, 32'h0000_0000, 32'h0000_0003, 64'h00000000_00000000, 33};
    vecs[7] = '{"div 7/-2",          1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 33};
    vecs[8] = '{"div -100/-7",       1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 64'hFFFFFFFE_0000000E, 33};
    vecs[9] = '{"divu 1234/0",       1'b0, 32'h0000_1234, 32'h0000_0000, 64'h00000000_00000000, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", {63'd0, bus.busy}, 64'd0);
    check("reset ready", {63'd0, bus.ready}, 64'd0);
    check("reset result", bus.result, 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      start_op(vecs[i].sgn, vecs[i].a, vecs[i].b);
      finish_op(vecs[i].name, vecs[i].exp, vecs[i].lat, 1'b1);
    end

    // Nonzero result first so the divide-by-zero zero result is visible.
    start_op(1'b0, 32'd100, 32'd7);
    finish_op("pre byzero", 64'h00000002_0000000E, 33, 1'b1);
    start_op(1'b0, 32'h0000_1234, 32'd0);
    finish_op("byzero", 64'd0, 1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("byzero hold ready", {63'd0, bus.ready}, 64'd1);
      check("byzero hold result", bus.result, 64'd0);
    end
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("byzero release ready", {63'd0, bus.ready}, 64'd0);

    // Annul ten cycles into a division.
    start_op(1'b0, 32'd77, 32'd5);
    finish_op("pre annul", 64'h00000002_0000000F, 33, 1'b1);
    start_op(1'b0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.annul = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("annul busy", {63'd0, bus.busy}, 64'd0);
    check("annul ready", {63'd0, bus.ready}, 64'd0);
    check("annul result kept", bus.result, last_res);
    // Annul in IDLE blocks acceptance even with start high.
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("annul blocks start", {63'd0, bus.busy}, 64'd0);
    bus.start = 1'b0;
    bus.annul = 1'b0;
    start_op(1'b1, 32'hFFFF_FF9C, 32'd7);
    finish_op("after annul", 64'hFFFFFFFE_FFFFFFF2, 33, 1'b1);

    // Reset in the middle of an operation with start held.
    start_op(1'b0, 32'hFFFF_FFFF, 32'd16);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.signed_div = 1'b1;
    bus.opa        = 32'hFFFF_FF9C;
    bus.opb        = 32'hFFFF_FFF9;
    @(posedge clk);
    @(negedge clk);
    check("midop reset busy", {63'd0, bus.busy}, 64'd0);
    check("midop reset ready", {63'd0, bus.ready}, 64'd0);
    check("midop reset result", bus.result, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    finish_op("after reset", 64'hFFFFFFFE_0000000E, 33, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
